// File: rtl/wb_led_chaser.sv
// Wishbone classic initiator that rotates a one-hot pattern into the LED register.
// Define WB_LED_CHASER_READBACK_EN to read back and verify every write.
module wb_led_chaser #(
   parameter int               WB_AW    = 32,
   parameter int               WB_DW    = 32,
   parameter logic [WB_AW-1:0] LED_ADDR = '0,
   parameter int               NUM_LEDS = 8,
   parameter int               PERIOD   = 1000,
   parameter int               TIMEOUT  = 15
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   output logic [WB_AW-1:0]     wb_adr_o,
   output logic [WB_DW-1:0]     wb_dat_o,
   output logic [WB_DW/8-1:0]   wb_sel_o,
   output logic                 wb_we_o,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   input  logic [WB_DW-1:0]     wb_dat_i,
   input  logic                 wb_ack_i,
   input  logic                 wb_err_i,
   output logic [NUM_LEDS-1:0]  pattern_o,
   output logic                 busy_o,
   output logic                 fault_o,
   output logic [1:0]           fault_code_o
);

`ifdef WB_LED_CHASER_READBACK_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif
   localparam int WCW = $clog2(PERIOD + 1);
   localparam int TCW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, WAIT, WRITE, READ, FAULT} state_t;

   state_t              state;
   logic                bus_act;
   logic [WCW-1:0]      wait_cnt;
   logic                wait_last;
   logic [TCW-1:0]      tmo_cnt;
   logic [NUM_LEDS-1:0] next_pattern;
   logic [1:0]          fault_nxt;

   assign next_pattern = (pattern_o << 1) | (pattern_o >> (NUM_LEDS - 1));

   // cyc and stb always move together; address and select are gated by the same flop
   assign wb_cyc_o = bus_act;
   assign wb_stb_o = bus_act;
   assign wb_adr_o = bus_act ? LED_ADDR : '0;
   assign wb_sel_o = {(WB_DW/8){bus_act}};

   // Outcome of the current strobe cycle; err beats ack
   always_comb begin
      fault_nxt = 2'b00;
      if (wb_err_i)
         fault_nxt = 2'b01;
      else if (wb_ack_i) begin
         if (state == READ && wb_dat_i != WB_DW'(pattern_o))
            fault_nxt = 2'b10;
      end else if (tmo_cnt == TCW'(TIMEOUT - 1))
         fault_nxt = 2'b11;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         bus_act      <= 1'b0;
         wb_we_o      <= 1'b0;
         wb_dat_o     <= '0;
         pattern_o    <= NUM_LEDS'(1);
         busy_o       <= 1'b0;
         fault_o      <= 1'b0;
         fault_code_o <= 2'b00;
         wait_cnt     <= '0;
         wait_last    <= 1'b0;
         tmo_cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en_i) begin
                  state     <= WAIT;
                  busy_o    <= 1'b1;
                  wait_cnt  <= WCW'(PERIOD - 1);
                  wait_last <= 1'b0;
               end
            end
            // One extra cycle at zero puts the strobe PERIOD+1 edges after WAIT entry
            WAIT: begin
               if (!en_i) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else if (wait_cnt != '0)
                  wait_cnt <= wait_cnt - 1'b1;
               else if (!wait_last)
                  wait_last <= 1'b1;
               else begin
                  state    <= WRITE;
                  bus_act  <= 1'b1;
                  wb_we_o  <= 1'b1;
                  wb_dat_o <= WB_DW'(next_pattern);
                  tmo_cnt  <= '0;
               end
            end
            WRITE, READ: begin
               if (!bus_act) begin
                  // READ turnaround: one idle bus cycle after the write, then strobe
                  bus_act <= 1'b1;
                  tmo_cnt <= '0;
               end else if (fault_nxt != 2'b00) begin
                  state        <= FAULT;
                  bus_act      <= 1'b0;
                  wb_we_o      <= 1'b0;
                  wb_dat_o     <= '0;
                  busy_o       <= 1'b0;
                  fault_o      <= 1'b1;
                  fault_code_o <= fault_nxt;
               end else if (wb_ack_i) begin
                  bus_act  <= 1'b0;
                  wb_we_o  <= 1'b0;
                  wb_dat_o <= '0;
                  if (state == WRITE)
                     pattern_o <= next_pattern;
                  if (!en_i) begin
                     state  <= IDLE;
                     busy_o <= 1'b0;
                  end else if (state == WRITE && READBACK)
                     state <= READ;
                  else begin
                     state     <= WAIT;
                     wait_cnt  <= WCW'(PERIOD - 1);
                     wait_last <= 1'b0;
                  end
               end else
                  tmo_cnt <= tmo_cnt + 1'b1;
            end
            FAULT: begin
               if (!en_i) begin
                  state        <= IDLE;
                  fault_o      <= 1'b0;
                  fault_code_o <= 2'b00;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_led_chaser.sv
// Randomized bench for wb_led_chaser: behavioural slave, bus monitor and a
// rotating-index reference model for the expected LED values and timing.
module tb_wb_led_chaser;
   localparam int AW = 32, DW = 32, NL = 8, PER = 4, TMO = 15, NW = 11;
   localparam logic [AW-1:0] ADDR = 32'h40;
`ifdef WB_LED_CHASER_READBACK_EN
   localparam int RB = 1;
`else
   localparam int RB = 0;
`endif

   logic clk = 1'b0;
   logic rst, en;
   logic [AW-1:0] adr;
   logic [DW-1:0] dat_o, dat_i;
   logic [DW/8-1:0] sel;
   logic we, cyc, stb, ack, err;
   logic [NL-1:0] pattern;
   logic busy, fault;
   logic [1:0] fcode;

   int pass_cnt = 0, chk_cnt = 0;

   always #5 clk = ~clk;

   wb_led_chaser #(.WB_AW(AW), .WB_DW(DW), .LED_ADDR(ADDR), .NUM_LEDS(NL),
                   .PERIOD(PER), .TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en),
      .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_we_o(we),
      .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_dat_i(dat_i), .wb_ack_i(ack),
      .wb_err_i(err), .pattern_o(pattern), .busy_o(busy), .fault_o(fault),
      .fault_code_o(fcode));

   // Slave: ack after slv_wait stall cycles. mode 1 = err+ack, 2 = silent, 3 = bad read data
   int slv_wait = 0, slv_mode = 0, stb_cnt = 0;
   logic [DW-1:0] led_reg = '0;
   logic hit;
   assign hit   = cyc && stb && (stb_cnt >= slv_wait) && (slv_mode != 2);
   assign ack   = hit;
   assign err   = hit && (slv_mode == 1);
   assign dat_i = (slv_mode == 3) ? 32'h5 : led_reg;

   always @(posedge clk) begin
      if (cyc && stb && !hit) stb_cnt <= stb_cnt + 1;
      else stb_cnt <= 0;
      if (hit && we && !err) led_reg <= dat_o;
   end

   // Bus monitor
   int cyc_no = 0, cur_len = 0, last_len = 0, rd_ack_cyc = -1, bus_bad = 0, b2b_bad = 0;
   bit stb_q = 0, done_q = 0;
   int wr_rise[$], rd_rise[$], wr_len[$], rd_len[$];
   logic [DW-1:0] wr_data[$];

   always @(posedge clk) begin
      cyc_no++;
      if (stb) begin
         if (!stb_q) begin
            cur_len = 0;
            if (we) wr_rise.push_back(cyc_no);
            else rd_rise.push_back(cyc_no);
         end
         cur_len++;
         if (!cyc || adr !== ADDR || sel !== '1) bus_bad++;
         if (ack || err) begin
            if (we) begin
               wr_len.push_back(cur_len);
               if (!err) wr_data.push_back(dat_o);
            end else begin
               rd_len.push_back(cur_len);
               rd_ack_cyc = cyc_no;
            end
         end
      end
      if (stb_q && !stb) last_len = cur_len;
      if (done_q && stb) b2b_bad++;
      done_q = stb && (ack || err);
      stb_q  = stb;
   end

   // Reference: the k-th committed pattern after reset is one-hot at index k mod NUM_LEDS
   function automatic logic [NL-1:0] model_pat(input int k);
      logic [NL-1:0] v;
      v = '0;
      v[k % NL] = 1'b1;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0; slv_mode = 0; slv_wait = 0;
      repeat (3) @(negedge clk);
      wr_rise.delete(); rd_rise.delete(); wr_len.delete(); rd_len.delete(); wr_data.delete();
      bus_bad = 0; b2b_bad = 0; rd_ack_cyc = -1; last_len = 0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_done(input int k, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (wr_data.size() >= k && rd_len.size() >= RB * k && !stb) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_fault(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (fault) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_stb(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (stb) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0;
      repeat (3) @(negedge clk);
      chk_cnt++; if ({cyc, stb, we} !== 3'b000) $display("FAIL rst_ctl: got %b want 000", {cyc, stb, we}); else pass_cnt++;
      chk_cnt++; if (adr !== '0 || sel !== '0) $display("FAIL rst_adr_sel: got %h/%h want 0/0", adr, sel); else pass_cnt++;
      chk_cnt++; if (dat_o !== '0) $display("FAIL rst_dat: got %h want 0", dat_o); else pass_cnt++;
      chk_cnt++; if (pattern !== model_pat(0)) $display("FAIL rst_pattern: got %h want %h", pattern, model_pat(0)); else pass_cnt++;
      chk_cnt++; if ({busy, fault, fcode} !== 4'b0000) $display("FAIL rst_status: got %b want 0000", {busy, fault, fcode}); else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_chase();
      int exp_w[$];
      int n;
      bit ok;
      do_reset();
      slv_wait = $urandom_range(0, 3);
      exp_w.push_back(slv_wait);
      en = 1'b1;
      for (n = 1; n <= 50; n++) begin
         @(posedge clk); #1;
         if (stb) break;
      end
      chk_cnt++; if (n !== PER + 2) $display("FAIL first_write_edges: got %0d want %0d", n, PER + 2); else pass_cnt++;
      for (int k = 1; k <= NW; k++) begin
         wait_done(k, ok);
         chk_cnt++; if (!ok) begin $display("FAIL chase_wait: write %0d got none want done", k); break; end else pass_cnt++;
         slv_wait = $urandom_range(0, 3);
         exp_w.push_back(slv_wait);
      end
      for (int i = 0; i < NW; i++) begin
         chk_cnt++; if (wr_data[i] !== DW'(model_pat(i + 1))) $display("FAIL chase_data[%0d]: got %h want %h", i, wr_data[i], DW'(model_pat(i + 1))); else pass_cnt++;
         chk_cnt++; if (wr_len[i] !== exp_w[i] + 1) $display("FAIL chase_wlen[%0d]: got %0d want %0d", i, wr_len[i], exp_w[i] + 1); else pass_cnt++;
      end
      for (int i = 0; i < NW - 1; i++) begin
         n = PER + (exp_w[i] + 1) + 1 + RB * (exp_w[i] + 1 + 1);
         chk_cnt++; if (wr_rise[i + 1] - wr_rise[i] !== n) $display("FAIL chase_interval[%0d]: got %0d want %0d", i, wr_rise[i + 1] - wr_rise[i], n); else pass_cnt++;
      end
      chk_cnt++; if (pattern !== model_pat(NW)) $display("FAIL chase_pattern: got %h want %h", pattern, model_pat(NW)); else pass_cnt++;
      chk_cnt++; if (led_reg !== DW'(model_pat(NW))) $display("FAIL chase_led: got %h want %h", led_reg, DW'(model_pat(NW))); else pass_cnt++;
      chk_cnt++; if (fault !== 1'b0) $display("FAIL chase_fault: got %b want 0", fault); else pass_cnt++;
      chk_cnt++; if (rd_rise.size() !== RB * NW) $display("FAIL chase_reads: got %0d want %0d", rd_rise.size(), RB * NW); else pass_cnt++;
      chk_cnt++; if (bus_bad !== 0 || b2b_bad !== 0) $display("FAIL chase_bus: got bad=%0d b2b=%0d want 0/0", bus_bad, b2b_bad); else pass_cnt++;
   endtask

   task automatic test_err();
      bit ok;
      logic [DW-1:0] led_before;
      do_reset();
      led_before = led_reg;
      slv_mode = 1;
      en = 1'b1;
      wait_fault(ok);
      chk_cnt++; if (!ok) $display("FAIL err_wait: got no fault want fault"); else pass_cnt++;
      chk_cnt++; if (fcode !== 2'b01) $display("FAIL err_code: got %b want 01", fcode); else pass_cnt++;
      chk_cnt++; if (pattern !== model_pat(0)) $display("FAIL err_pattern: got %h want %h", pattern, model_pat(0)); else pass_cnt++;
      chk_cnt++; if ({cyc, stb, busy} !== 3'b000) $display("FAIL err_idle: got %b want 000", {cyc, stb, busy}); else pass_cnt++;
      chk_cnt++; if (led_reg !== led_before) $display("FAIL err_led: got %h want %h", led_reg, led_before); else pass_cnt++;
   endtask

   task automatic test_timeout();
      bit ok;
      do_reset();
      slv_mode = 2;
      en = 1'b1;
      wait_fault(ok);
      chk_cnt++; if (!ok) $display("FAIL tmo_wait: got no fault want fault"); else pass_cnt++;
      chk_cnt++; if (fcode !== 2'b11) $display("FAIL tmo_code: got %b want 11", fcode); else pass_cnt++;
      chk_cnt++; if (cyc !== 1'b0) $display("FAIL tmo_cyc: got %b want 0", cyc); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (last_len !== TMO) $display("FAIL tmo_len: got %0d want %0d", last_len, TMO); else pass_cnt++;
      chk_cnt++; if (pattern !== model_pat(0)) $display("FAIL tmo_pattern: got %h want %h", pattern, model_pat(0)); else pass_cnt++;
   endtask

   task automatic test_readback();
`ifdef WB_LED_CHASER_READBACK_EN
      bit ok;
      int fault_cyc;
      do_reset();
      slv_mode = 3;
      en = 1'b1;
      wait_fault(ok);
      fault_cyc = cyc_no;
      chk_cnt++; if (!ok) $display("FAIL rb_wait: got no fault want fault"); else pass_cnt++;
      chk_cnt++; if (fcode !== 2'b10) $display("FAIL rb_code: got %b want 10", fcode); else pass_cnt++;
      chk_cnt++; if (pattern !== model_pat(1)) $display("FAIL rb_pattern: got %h want %h", pattern, model_pat(1)); else pass_cnt++;
      chk_cnt++; if (cyc !== 1'b0) $display("FAIL rb_cyc: got %b want 0", cyc); else pass_cnt++;
      chk_cnt++; if (fault_cyc !== rd_ack_cyc) $display("FAIL rb_latency: got edge %0d want %0d", fault_cyc, rd_ack_cyc); else pass_cnt++;
`endif
   endtask

   task automatic test_en_drop();
      bit ok;
      do_reset();
      slv_wait = 3;
      en = 1'b1;
      wait_stb(ok);
      chk_cnt++; if (!ok) $display("FAIL drop_stb: got no strobe want strobe"); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL drop_busy_wr: got %b want 1", busy); else pass_cnt++;
      en = 1'b0;
      repeat (PER + 8) @(negedge clk);
      chk_cnt++; if (pattern !== model_pat(1)) $display("FAIL drop_pattern: got %h want %h", pattern, model_pat(1)); else pass_cnt++;
      chk_cnt++; if (led_reg !== DW'(model_pat(1))) $display("FAIL drop_led: got %h want %h", led_reg, DW'(model_pat(1))); else pass_cnt++;
      chk_cnt++; if (wr_len[0] !== 4) $display("FAIL drop_wlen: got %0d want 4", wr_len[0]); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0 || fault !== 1'b0) $display("FAIL drop_idle: got busy=%b fault=%b want 0/0", busy, fault); else pass_cnt++;
      chk_cnt++; if (wr_rise.size() !== 1 || rd_rise.size() !== 0) $display("FAIL drop_xfers: got wr=%0d rd=%0d want 1/0", wr_rise.size(), rd_rise.size()); else pass_cnt++;
      en = 1'b1;
      @(negedge clk);
      chk_cnt++; if (busy !== 1'b1) $display("FAIL wait_busy: got %b want 1", busy); else pass_cnt++;
      en = 1'b0;
      @(negedge clk);
      chk_cnt++; if (busy !== 1'b0) $display("FAIL wait_drop: got %b want 0", busy); else pass_cnt++;
      repeat (PER + 4) @(negedge clk);
      chk_cnt++; if (wr_rise.size() !== 1) $display("FAIL wait_nowrite: got %0d want 1", wr_rise.size()); else pass_cnt++;
   endtask

   task automatic test_fault_recover();
      bit ok;
      do_reset();
      slv_wait = $urandom_range(0, 2);
      en = 1'b1;
      wait_done(3, ok);
      chk_cnt++; if (!ok) $display("FAIL rec_pre: got no writes want 3"); else pass_cnt++;
      slv_mode = 2;
      wait_fault(ok);
      chk_cnt++; if (!ok || fcode !== 2'b11) $display("FAIL rec_fault: got %b want 11", fcode); else pass_cnt++;
      repeat (5) @(negedge clk);
      chk_cnt++; if (fault !== 1'b1 || stb !== 1'b0) $display("FAIL rec_hold: got fault=%b stb=%b want 1/0", fault, stb); else pass_cnt++;
      en = 1'b0;
      @(negedge clk);
      chk_cnt++; if ({fault, fcode} !== 3'b000) $display("FAIL rec_clear: got %b want 000", {fault, fcode}); else pass_cnt++;
      chk_cnt++; if (pattern !== model_pat(3)) $display("FAIL rec_pattern: got %h want %h", pattern, model_pat(3)); else pass_cnt++;
      slv_mode = 0;
      en = 1'b1;
      wait_done(4, ok);
      chk_cnt++; if (!ok || wr_data[3] !== DW'(model_pat(4))) $display("FAIL rec_next: got %h want %h", wr_data[3], DW'(model_pat(4))); else pass_cnt++;
   endtask

   task automatic test_reset_midcycle();
      bit ok;
      do_reset();
      slv_mode = 2;
      en = 1'b1;
      wait_stb(ok);
      chk_cnt++; if (!ok) $display("FAIL mid_stb: got no strobe want strobe"); else pass_cnt++;
      rst = 1'b1;
      #1;
      chk_cnt++; if ({cyc, stb} !== 2'b00) $display("FAIL mid_drop: got %b want 00", {cyc, stb}); else pass_cnt++;
      chk_cnt++; if ({busy, fault} !== 2'b00) $display("FAIL mid_status: got %b want 00", {busy, fault}); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0; en = 1'b0; slv_mode = 0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0;
      test_reset();
      test_chase();
      test_err();
      test_timeout();
      test_readback();
      test_en_drop();
      test_fault_recover();
      test_reset_midcycle();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
